// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron: table[in_data] through a two-stage valid/ready pipe, 2-cycle latency.
// Backpressure: both stages hold while out_valid & !out_ready; table is swept to zero after every reset.
module lut_neuron_prog #(
  parameter  int FAN_IN   = 4,
  parameter  int IN_BITS  = 2,
  parameter  int OUT_BITS = 2,
  localparam int ADDR_W   = FAN_IN * IN_BITS,
  localparam int DEPTH    = 1 << ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_cnt_nxt;

  logic                w_tbl_we;
  logic [ADDR_W-1:0]   w_tbl_addr;
  logic [OUT_BITS-1:0] w_tbl_dat;
  logic [OUT_BITS-1:0] r_table [DEPTH];

  logic                r_v1;
  logic [ADDR_W-1:0]   r_addr1;
  logic                r_out_vld;
  logic [OUT_BITS-1:0] r_out_dat;

  logic                w_run;
  logic                w_adv;
  logic                w_accept;

  // The sweep owns the table write port in CLEAR; config writes are dropped then.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_tbl_we      = 1'b0;
    w_tbl_addr    = cfg_addr;
    w_tbl_dat     = cfg_data;
    case (r_state)
      ST_CLEAR: begin
        w_tbl_we   = 1'b1;
        w_tbl_addr = r_clr_cnt;
        w_tbl_dat  = '0;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_tbl_we = cfg_we;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_tbl_we) begin
      r_table[w_tbl_addr] <= w_tbl_dat;
    end
  end

  assign w_run    = (r_state == ST_RUN);
  assign w_adv    = !r_out_vld || out_ready;
  assign w_accept = in_valid && in_ready;

  // S2 samples the table before this edge's write lands, so a colliding write yields the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_addr1   <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else if (w_adv) begin
      r_out_vld <= r_v1;
      r_out_dat <= r_table[r_addr1];
      r_v1      <= w_accept;
      r_addr1   <= in_data;
    end
  end

  assign cfg_busy  = !w_run;
  assign in_ready  = w_run && !cfg_we && w_adv;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Directed bench for lut_neuron_prog: scoreboard of expected lookups, latency and stall-stability checks.
module tb_lut_neuron_prog;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [1:0]        cfg_data;
  logic              cfg_busy;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_data;

  lut_neuron_prog dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  int         acc_total = 0;
  bit         lat_chk = 1'b0;
  bit         running = 1'b0;
  bit         stalled = 1'b0;
  logic [1:0] held;
  logic [1:0] mdl [DEPTH];
  logic [1:0] exp_q [$];
  int         acc_cyc_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // One clock: sample the handshakes with settled inputs, update the model, then cross the edge.
  task automatic step();
    logic [1:0] e;
    int         a;
    #1;
    if (stalled) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {30'd0, out_data}, {30'd0, held});
    end
    stalled = out_valid && !out_ready;
    held    = out_data;
    if (in_valid && in_ready) begin
      exp_q.push_back(mdl[in_data]);
      acc_cyc_q.push_back(cyc);
      acc_total++;
    end
    if (out_valid && out_ready) begin
      chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", {30'd0, out_data}, {30'd0, e});
      end
      if (acc_cyc_q.size() != 0) begin
        a = acc_cyc_q.pop_front();
        if (lat_chk) chk("latency", cyc - a, 32'd2);
      end
    end
    if (cfg_we && running && !rst) mdl[cfg_addr] = cfg_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic wait_sweep();
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (cfg_busy && n < 1000) begin
      if (in_ready || out_valid) bad++;
      step();
      n++;
    end
    chk("sweep_len", n, DEPTH);
    chk("sweep_quiet", bad, 32'd0);
    running = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 2'b00;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] a);
    in_valid = 1'b1;
    in_data  = a;
    step();
    in_valid = 1'b0;
    drain();
  endtask

  logic [7:0] stream_a [4];
  bit         rdy_pat  [4];
  int         acc0;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 2'b00;

    // Reset state
    step();
    chk("rst_busy", {31'd0, cfg_busy}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {30'd0, out_data}, 32'd0);
    step(); step();
    rst = 1'b0;

    // Sweep with a vector already offered; it must wait for RUN
    in_valid = 1'b1;
    in_data  = 8'h5A;
    wait_sweep();
    acc0 = acc_total;
    step();
    chk("first_accept", acc_total - acc0, 32'd1);
    drain();

    // Program and stream back-to-back
    cfg_write(8'h0F, 2'b01);
    cfg_write(8'h4F, 2'b01);
    cfg_write(8'hCF, 2'b00);
    stream_a[0] = 8'h0F; stream_a[1] = 8'h4F; stream_a[2] = 8'hCF; stream_a[3] = 8'hFF;
    lat_chk = 1'b1;
    acc0 = acc_total;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = stream_a[i];
      step();
    end
    chk("b2b_accepts", acc_total - acc0, 32'd4);
    drain();
    lat_chk = 1'b0;

    // Continuous input under toggling backpressure
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h0F;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        out_ready = rdy_pat[i];
        step();
      end
    end
    drain();

    // Config write blocks a concurrent input
    in_valid = 1'b1;
    in_data  = 8'h33;
    cfg_we   = 1'b1;
    cfg_addr = 8'h1F;
    cfg_data = 2'b11;
    #1;
    chk("cfg_blocks_ready", {31'd0, in_ready}, 32'd0);
    acc0 = acc_total;
    step();
    chk("cfg_no_accept", acc_total - acc0, 32'd0);
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    drain();
    lookup(8'h1F);

    // Read/write collision on the S1 address
    cfg_write(8'h2F, 2'b01);
    in_valid = 1'b1;
    in_data  = 8'h2F;
    step();
    in_valid = 1'b0;
    cfg_write(8'h2F, 2'b10);
    drain();
    lookup(8'h2F);

    // Reset with two vectors in flight
    in_valid = 1'b1;
    in_data  = 8'h0F;
    step();
    in_data  = 8'h4F;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    stalled = 1'b0;
    running = 1'b0;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_busy", {31'd0, cfg_busy}, 32'd1);
    out_ready = 1'b1;
    wait_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
